// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types used by the register file, ALU, decode
// and the pipeline registers.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    // Bit 0 is the MSB, matching the ALU operand ports.
    typedef logic [0:DATA_W-1] word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // True when an enabled port targets a real (non-zero) register at the same address.
    function automatic logic addr_hit(input logic en, input reg_addr_t a, input reg_addr_t b);
        return en && (a == b) && (a != REG_ZERO);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on accepted issue, cleared on writeback.
module reg_scoreboard #(
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int NREGS  = mips_pkg::NREGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dst,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              stall,
    output logic              issue_accept
);
    import mips_pkg::*;

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_nxt;
    logic             wb_clr;
    logic             iss_set;

    assign wb_clr  = we && (wr_addr != REG_ZERO);
    assign iss_set = issue_accept && (issue_dst != REG_ZERO);

    // A writeback to the operand's register this cycle is forwarded, so it no longer blocks.
    assign rs_busy      = pending[rs_addr] && !(we && (wr_addr == rs_addr));
    assign rt_busy      = pending[rt_addr] && !(we && (wr_addr == rt_addr));
    assign stall        = rs_busy || rt_busy;
    assign issue_accept = issue_valid && !stall;

    // Set is applied after clear so a newer producer to the same register stays outstanding.
    always_comb begin
        pending_nxt = pending;
        if (wb_clr)
            pending_nxt[wr_addr] = 1'b0;
        if (iss_set)
            pending_nxt[issue_dst] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

endmodule

// File: rtl/reg_file_sb.sv
// 32x32 MIPS register file with write-first bypass and a pending-write scoreboard
// feeding the decode stall.
module reg_file_sb #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int NREGS  = mips_pkg::NREGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [0:DATA_W-1] rd1,
    output logic [0:DATA_W-1] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [0:DATA_W-1] wr_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dst,
    output logic              issue_accept,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              stall
);
    import mips_pkg::*;

    logic [0:DATA_W-1] regs [NREGS];
    logic              wr_en;

    assign wr_en = we && (wr_addr != REG_ZERO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Write-first: same-cycle writeback data wins over the stored value; r0 is hard zero.
    always_comb begin
        rd1 = regs[rs_addr];
        if (rs_addr == REG_ZERO)
            rd1 = '0;
        else if (addr_hit(we, wr_addr, rs_addr))
            rd1 = wr_data;
    end

    always_comb begin
        rd2 = regs[rt_addr];
        if (rt_addr == REG_ZERO)
            rd2 = '0;
        else if (addr_hit(we, wr_addr, rt_addr))
            rd2 = wr_data;
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_sb (
        .clk          (clk),
        .rst_n        (rst_n),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .we           (we),
        .wr_addr      (wr_addr),
        .issue_valid  (issue_valid),
        .issue_dst    (issue_dst),
        .rs_busy      (rs_busy),
        .rt_busy      (rt_busy),
        .stall        (stall),
        .issue_accept (issue_accept)
    );

endmodule
